// File: rtl/datapath_pkg.sv
// Shared datapath types: serial FSM state encoding and default operand width.
package datapath_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/datapath_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface datapath_serial_subtractor_if
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/datapath_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: D = a - b - Bin, Bout = borrow.
module datapath_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = a ^ b ^ Bin;
  assign Bout = (~a & b) | (~a & Bin) | (b & Bin);
endmodule

// File: rtl/datapath_serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell per clock.
module datapath_serial_subtractor
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  datapath_serial_subtractor_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_n;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q;
  logic [WIDTH-1:0]   res_next_c;
  logic [CNT_W-1:0]   cnt_q;
  logic               borrow_q, a_msb_q, b_msb_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_out_q, overflow_q, busy_q, done_q;
  logic               d_c, bout_c, load_c, step_c, last_c;

  datapath_full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .Bin  (borrow_q),
    .D    (d_c),
    .Bout (bout_c)
  );

  assign res_next_c = {d_c, res_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Next state plus load/step strobes for the datapath
  always_comb begin
    state_n = ST_IDLE;
    load_c  = 1'b0;
    step_c  = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step_c  = 1'b1;
        last_c  = (cnt_q == CNT_W'(WIDTH - 1));
        state_n = last_c ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (load_c) begin
        a_sh_q   <= bus.a;
        b_sh_q   <= bus.b;
        borrow_q <= 1'b0;
        cnt_q    <= '0;
        a_msb_q  <= bus.a[WIDTH-1];
        b_msb_q  <= bus.b[WIDTH-1];
      end else if (step_c) begin
        a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_q <= res_next_c;
        borrow_q <= bout_c;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      // Results only move on the final bit; they hold through SHIFT
      if (last_c) begin
        diff_q       <= res_next_c;
        borrow_out_q <= bout_c;
        overflow_q   <= (a_msb_q != b_msb_q) && (d_c != a_msb_q);
      end
      busy_q <= (state_n != ST_IDLE);
      done_q <= (state_n == ST_DONE);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule
